// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit serializer.
// Holds the engine state encoding, the bit-stuffing run length and the run-counter helper.
package tx_pkg;

    localparam int unsigned STUFF_RUN = 6;
    localparam int unsigned ONES_W    = $clog2(STUFF_RUN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    // Consecutive-ones counter update for one driven data bit, saturating at STUFF_RUN.
    function automatic logic [ONES_W-1:0] ones_next(
        input logic [ONES_W-1:0] cur,
        input logic              bit_v
    );
        if (!bit_v) begin
            return '0;
        end
        if (cur == ONES_W'(STUFF_RUN)) begin
            return cur;
        end
        return cur + ONES_W'(1);
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous word FIFO feeding the serializer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: contents are only read behind the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/tx_serializer.sv
// Parallel-to-serial transmit engine: word FIFO, strobe-paced shifter and optional bit stuffing.
// Words stream back-to-back; the line returns to IDLE_LEVEL with a done or underrun pulse.
module tx_serializer
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          STUFF_EN   = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_strobe,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              eop,
    output logic              serial_out,
    output logic              tx_active,
    output logic              stuffed,
    output logic              done,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned BL_W  = $clog2(DATA_W);

    tx_state_e         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BL_W-1:0]   r_bits_left;
    logic [ONES_W-1:0] r_ones;
    logic              r_eop_pending;
    logic              r_serial;
    logic              r_tx_active;
    logic              r_stuffed;
    logic              r_done;
    logic              r_underrun;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_rdata;
    logic              w_load_bit;
    logic [DATA_W-1:0] w_load_rest;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shift_rest;
    logic              w_stuff_now;
    logic              w_word_end;
    logic              w_finish;
    logic              w_done_now;
    logic              w_eop_take;

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign in_ready = (w_count < CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;

    // Bit selection for a freshly loaded word and for the word in flight.
    assign w_load_bit   = MSB_FIRST ? w_rdata[DATA_W-1] : w_rdata[0];
    assign w_load_rest  = MSB_FIRST ? (w_rdata << 1) : (w_rdata >> 1);
    assign w_next_bit   = MSB_FIRST ? r_shreg[DATA_W-1] : r_shreg[0];
    assign w_shift_rest = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

    assign w_stuff_now = STUFF_EN && (r_ones == ONES_W'(STUFF_RUN));
    assign w_word_end  = (r_state == SHIFT) && !w_stuff_now && (r_bits_left == '0);
    assign w_pop       = shift_strobe && !w_empty && ((r_state == IDLE) || w_word_end);
    assign w_finish    = shift_strobe && w_word_end && w_empty;
    assign w_done_now  = w_finish && r_eop_pending;

    // eop marks a word already queued, one written now, or the word still on the line.
    assign w_eop_take = eop && (w_push || !w_empty || ((r_state == SHIFT) && !w_finish));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_bits_left   <= '0;
            r_ones        <= '0;
            r_eop_pending <= 1'b0;
            r_serial      <= IDLE_LEVEL;
            r_tx_active   <= 1'b0;
            r_stuffed     <= 1'b0;
            r_done        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_stuffed  <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;

            if (w_eop_take) begin
                r_eop_pending <= 1'b1;
            end else if (w_done_now) begin
                r_eop_pending <= 1'b0;
            end

            if (shift_strobe) begin
                case (r_state)
                    IDLE: begin
                        if (!w_empty) begin
                            r_shreg     <= w_load_rest;
                            r_serial    <= w_load_bit;
                            r_tx_active <= 1'b1;
                            r_bits_left <= BL_W'(DATA_W - 1);
                            r_ones      <= ones_next('0, w_load_bit);
                            r_state     <= SHIFT;
                        end else begin
                            r_serial    <= IDLE_LEVEL;
                            r_tx_active <= 1'b0;
                            r_ones      <= '0;
                        end
                    end
                    SHIFT: begin
                        if (w_stuff_now) begin
                            r_serial  <= 1'b0;
                            r_stuffed <= 1'b1;
                            r_ones    <= '0;
                        end else if (r_bits_left != '0) begin
                            r_serial    <= w_next_bit;
                            r_shreg     <= w_shift_rest;
                            r_bits_left <= r_bits_left - BL_W'(1);
                            r_ones      <= ones_next(r_ones, w_next_bit);
                        end else if (!w_empty) begin
                            r_shreg     <= w_load_rest;
                            r_serial    <= w_load_bit;
                            r_bits_left <= BL_W'(DATA_W - 1);
                            r_ones      <= ones_next(r_ones, w_load_bit);
                        end else begin
                            r_serial    <= IDLE_LEVEL;
                            r_tx_active <= 1'b0;
                            r_ones      <= '0;
                            r_done      <= r_eop_pending;
                            r_underrun  <= !r_eop_pending;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign serial_out = r_serial;
    assign tx_active  = r_tx_active;
    assign stuffed    = r_stuffed;
    assign done       = r_done;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: a packet-level model queues the expected line events,
// and a monitor compares every strobe-following cycle against the queue.
module tb_tx_serializer;

    localparam int unsigned DATA_W = 8;
    localparam int          RUN    = 6;

    localparam logic [1:0] K_DATA  = 2'd0;
    localparam logic [1:0] K_STUFF = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;
    localparam logic [1:0] K_UNDER = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       val;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              shift_strobe;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              eop;
    logic              serial_out;
    logic              tx_active;
    logic              stuffed;
    logic              done;
    logic              underrun;

    exp_t       exp_q[$];
    logic [7:0] pk[$];
    int         n_checks;
    int         n_errors;
    bit         mon_en;
    bit         strobe_en;
    int         strobe_period;

    tx_serializer #(
        .DATA_W     (DATA_W),
        .DEPTH      (4),
        .MSB_FIRST  (1'b0),
        .STUFF_EN   (1'b1),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .shift_strobe (shift_strobe),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .eop          (eop),
        .serial_out   (serial_out),
        .tx_active    (tx_active),
        .stuffed      (stuffed),
        .done         (done),
        .underrun     (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line activity for a packet: LSB-first bits, a 0 inserted after every run of six 1s,
    // then the terminating event.
    task automatic model_packet(input logic [7:0] words[$], input bit with_eop);
        int   run;
        logic v;
        exp_t e;
        run = 0;
        foreach (words[i]) begin
            for (int b = 0; b < 8; b++) begin
                v = words[i][b];
                e.kind = K_DATA;
                e.val  = v;
                exp_q.push_back(e);
                run = v ? run + 1 : 0;
                if (run == RUN) begin
                    e.kind = K_STUFF;
                    e.val  = 1'b0;
                    exp_q.push_back(e);
                    run = 0;
                end
            end
        end
        e.kind = with_eop ? K_DONE : K_UNDER;
        e.val  = 1'b1;
        exp_q.push_back(e);
    endtask

    // Strobe generator: one-cycle pulse every strobe_period clocks while enabled.
    initial begin
        int cnt;
        cnt = 0;
        shift_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (strobe_en) begin
                cnt++;
                if (cnt >= strobe_period) begin
                    shift_strobe = 1'b1;
                    cnt = 0;
                end else begin
                    shift_strobe = 1'b0;
                end
            end else begin
                shift_strobe = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: strobe-following cycles are compared against the queue, other cycles must hold.
    initial begin
        bit   strobed;
        bit   rsted;
        logic prev_ser;
        logic prev_act;
        exp_t e;
        prev_ser = 1'b1;
        prev_act = 1'b0;
        forever begin
            @(posedge clk);
            strobed = shift_strobe && !rst;
            rsted   = rst;
            @(negedge clk);
            if (mon_en) begin
                if (strobed) begin
                    if (tx_active || done || underrun) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 32'({tx_active, done, underrun}), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.kind == K_DATA || e.kind == K_STUFF) begin
                                check("bit_active", 32'(tx_active), 32'd1);
                                check("bit_value", 32'(serial_out), 32'(e.val));
                                check("stuff_flag", 32'(stuffed), 32'(e.kind == K_STUFF));
                                check("no_end_pulse", 32'({done, underrun}), 32'd0);
                            end else begin
                                check("end_kind", 32'({done, underrun}),
                                      (e.kind == K_DONE) ? 32'd2 : 32'd1);
                                check("end_idle_level", 32'(serial_out), 32'd1);
                                check("end_active", 32'(tx_active), 32'd0);
                                check("end_stuff", 32'(stuffed), 32'd0);
                            end
                        end
                    end else begin
                        check("idle_level", 32'({serial_out, stuffed}), 32'd2);
                    end
                end else begin
                    check("pulse_quiet", 32'({stuffed, done, underrun}), 32'd0);
                    if (!rsted) begin
                        check("hold", 32'({serial_out, tx_active}), 32'({prev_ser, prev_act}));
                    end
                end
            end
            prev_ser = serial_out;
            prev_act = tx_active;
        end
    end

    // Called at a negedge; presents one word and completes the handshake, eop only on acceptance.
    task automatic push_word(input logic [7:0] d, input bit last_eop);
        int budget;
        budget = 2000;
        in_valid = 1'b1;
        in_data  = d;
        eop      = 1'b0;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("write_timeout", 32'(in_ready), 32'd1);
        eop = last_eop;
        @(negedge clk);
        in_valid = 1'b0;
        eop      = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 5000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_packet(input logic [7:0] words[$], input bit with_eop, input int period);
        model_packet(words, with_eop);
        strobe_period = period;
        strobe_en     = 1'b1;
        foreach (words[i]) begin
            push_word(words[i], with_eop && (i == words.size() - 1));
        end
        wait_drain();
        strobe_en = 1'b0;
        repeat (3) @(negedge clk);
        check("post_ready", 32'(in_ready), 32'd1);
        check("post_idle", 32'({serial_out, tx_active}), 32'd2);
    endtask

    initial begin
        exp_t e;
        int   budget;
        n_checks      = 0;
        n_errors      = 0;
        mon_en        = 1'b0;
        strobe_en     = 1'b0;
        strobe_period = 4;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        eop           = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_pulses", 32'({tx_active, stuffed, done, underrun}), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // A lone eop with nothing queued must not end the next packet early.
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;

        pk.delete(); pk.push_back(8'hA5);
        run_packet(pk, 1'b1, 4);

        pk.delete(); pk.push_back(8'h0F); pk.push_back(8'hF0);
        run_packet(pk, 1'b1, 4);

        pk.delete(); pk.push_back(8'hFF); pk.push_back(8'h00);
        run_packet(pk, 1'b1, 3);

        pk.delete(); pk.push_back(8'h3C);
        run_packet(pk, 1'b0, 4);

        // Stuff bit owed after the last data bit precedes done.
        pk.delete(); pk.push_back(8'hFC);
        run_packet(pk, 1'b1, 2);

        // Full FIFO: fifth write held until a pop frees a slot.
        pk.delete();
        for (int i = 0; i < 5; i++) pk.push_back(8'($urandom));
        model_packet(pk, 1'b1);
        strobe_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(pk[i], 1'b0);
        check("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = pk[4];
        repeat (3) begin
            @(negedge clk);
            check("full_hold", 32'(in_ready), 32'd0);
        end
        strobe_period = 2;
        strobe_en     = 1'b1;
        budget        = 2000;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("full_release", 32'(in_ready), 32'd1);
        eop = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        eop      = 1'b0;
        wait_drain();
        strobe_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset after three bits of 0x81: the rest of the word must never appear.
        e.kind = K_DATA;
        e.val = 1'b1; exp_q.push_back(e);
        e.val = 1'b0; exp_q.push_back(e);
        e.val = 1'b0; exp_q.push_back(e);
        strobe_period = 4;
        strobe_en     = 1'b1;
        push_word(8'h81, 1'b0);
        wait_drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_serial", 32'(serial_out), 32'd1);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_pulses", 32'({tx_active, done, underrun}), 32'd0);
        repeat (60) @(negedge clk);
        strobe_en = 1'b0;
        pk.delete(); pk.push_back(8'h55);
        run_packet(pk, 1'b1, 4);

        // Randomised packets, biased toward 0xFF so stuffing crosses word boundaries.
        for (int p = 0; p < 20; p++) begin
            int nw;
            nw = int'($urandom_range(1, 6));
            pk.delete();
            for (int i = 0; i < nw; i++) begin
                pk.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            end
            run_packet(pk, $urandom_range(0, 4) != 0, int'($urandom_range(1, 5)));
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
